add_mul_pipe: RTL and testbench

ADD_MUL_PIPE -- requirements
Module: add_mul_pipe

---
 rtl/add_mul_pipe.sv | 148 ++++++++++++++
 tb/tb_add_mul_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_mul_pipe.sv
// add_mul_pipe: per-lane signed y = a*b + (mode ? accumulator : c), STAGES deep, with backpressure.
// Define ADD_MUL_PIPE_SAT_EN to saturate out-of-range results instead of wrapping them.
module add_mul_pipe #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic                   acc_clr,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [LANES*WIDTH-1:0] c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] y,
  output logic [LANES-1:0]       ovf
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic                   w_stall;
  logic                   w_adv;
  logic [LANES*PW-1:0]    w_in_prod;
  logic                   w_fin_vld;
  logic                   w_fin_mode;
  logic [LANES*PW-1:0]    w_fin_prod;
  logic [LANES*WIDTH-1:0] w_fin_c;
  logic [LANES*WIDTH-1:0] w_y_next;
  logic [LANES-1:0]       w_ovf_next;
  logic                   r_out_vld;
  logic [LANES*WIDTH-1:0] r_y;
  logic [LANES-1:0]       r_ovf;

  assign w_stall   = r_out_vld & ~out_ready;
  assign w_adv     = ~w_stall;
  assign in_ready  = w_adv;
  assign out_valid = r_out_vld;
  assign y         = r_y;
  assign ovf       = r_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_mul
      logic signed [PW-1:0] w_ax;
      logic signed [PW-1:0] w_bx;
      assign w_ax = {{WIDTH{a[gi*WIDTH+WIDTH-1]}}, a[gi*WIDTH +: WIDTH]};
      assign w_bx = {{WIDTH{b[gi*WIDTH+WIDTH-1]}}, b[gi*WIDTH +: WIDTH]};
      assign w_in_prod[gi*PW +: PW] = w_ax * w_bx;
    end

    // The product is formed at the input; the addend is applied only in the final stage
    // so that back-to-back accumulate transactions see each other's results.
    if (STAGES == 1) begin : g_bypass
      assign w_fin_vld  = in_valid;
      assign w_fin_mode = mode;
      assign w_fin_prod = w_in_prod;
      assign w_fin_c    = c;
    end else begin : g_pipe
      logic                   r_vld  [STAGES-1];
      logic                   r_mode [STAGES-1];
      logic [LANES*PW-1:0]    r_prod [STAGES-1];
      logic [LANES*WIDTH-1:0] r_c    [STAGES-1];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < STAGES-1; s++) begin
            r_vld[s]  <= 1'b0;
            r_mode[s] <= 1'b0;
            r_prod[s] <= '0;
            r_c[s]    <= '0;
          end
        end else if (w_adv) begin
          r_vld[0]  <= in_valid;
          r_mode[0] <= mode;
          r_prod[0] <= w_in_prod;
          r_c[0]    <= c;
          for (int s = 1; s < STAGES-1; s++) begin
            r_vld[s]  <= r_vld[s-1];
            r_mode[s] <= r_mode[s-1];
            r_prod[s] <= r_prod[s-1];
            r_c[s]    <= r_c[s-1];
          end
        end
      end

      assign w_fin_vld  = r_vld[STAGES-2];
      assign w_fin_mode = r_mode[STAGES-2];
      assign w_fin_prod = r_prod[STAGES-2];
      assign w_fin_c    = r_c[STAGES-2];
    end

    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [WIDTH-1:0] r_acc;
      logic signed [WIDTH-1:0] w_add;
      logic signed [WIDTH-1:0] w_yl;
      logic signed [PW-1:0]    w_p;
      logic signed [SW-1:0]    w_sum;
      logic                    w_hi;
      logic                    w_lo;

      // A clear coinciding with an accumulate transaction makes it start from zero.
      assign w_p   = w_fin_prod[gi*PW +: PW];
      assign w_add = w_fin_mode ? (acc_clr ? '0 : r_acc) : w_fin_c[gi*WIDTH +: WIDTH];
      assign w_sum = {w_p[PW-1], w_p} + {{(SW-WIDTH){w_add[WIDTH-1]}}, w_add};
      assign w_hi  = w_sum > MAXV;
      assign w_lo  = w_sum < MINV;
`ifdef ADD_MUL_PIPE_SAT_EN
      assign w_yl  = w_hi ? MAXV[WIDTH-1:0] : (w_lo ? MINV[WIDTH-1:0] : w_sum[WIDTH-1:0]);
`else
      assign w_yl  = w_sum[WIDTH-1:0];
`endif

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_acc <= '0;
        end else if (w_adv && w_fin_vld && w_fin_mode) begin
          r_acc <= w_yl;
        end else if (acc_clr) begin
          r_acc <= '0;
        end
      end

      assign w_y_next[gi*WIDTH +: WIDTH] = w_yl;
      assign w_ovf_next[gi]              = w_hi | w_lo;
    end
  endgenerate

  // y/ovf only load on a real result so they stay stable across bubbles and stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_vld <= 1'b0;
      r_y       <= '0;
      r_ovf     <= '0;
    end else if (w_adv) begin
      r_out_vld <= w_fin_vld;
      if (w_fin_vld) begin
        r_y   <= w_y_next;
        r_ovf <= w_ovf_next;
      end
    end
  end
endmodule

// File: tb/tb_add_mul_pipe.sv
// Self-checking bench for add_mul_pipe: directed vectors, accumulate/stall/reset sequences, random vs model.
// Honours ADD_MUL_PIPE_SAT_EN to pick wrap or saturate expectations.
module tb_add_mul_pipe;
  localparam int W = 8;
  localparam int L = 4;
  localparam int S = 2;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           mode;
  logic           acc_clr;
  logic [L*W-1:0] a;
  logic [L*W-1:0] b;
  logic [L*W-1:0] c;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] y;
  logic [L-1:0]   ovf;

  add_mul_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .acc_clr(acc_clr), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ntx = 0;

  typedef struct {
    logic           v;
    logic           mode;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [L*W-1:0] c;
  } op_t;

  typedef struct {
    string          name;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [L*W-1:0] c;
    logic [L*W-1:0] ey;
    logic [L-1:0]   eovf;
  } vec_t;

  // Reference model: ops wait S-1 slots, then the result register; accumulators are plain ints.
  op_t            pq[$];
  int             macc[L];
  logic           m_v;
  logic [L*W-1:0] m_y;
  logic [L-1:0]   m_ovf;

  logic           cand_v;
  logic [L*W-1:0] cand_y;
  logic [L-1:0]   cand_ovf;
  logic [L*W-1:0] obs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    op_t idle;
    idle = '{v: 1'b0, mode: 1'b0, a: '0, b: '0, c: '0};
    pq.delete();
    for (int i = 0; i < S-1; i++) pq.push_back(idle);
    for (int i = 0; i < L; i++) macc[i] = 0;
    m_v = 1'b0;
    m_y = '0;
    m_ovf = '0;
    cand_v = 1'b0;
  endfunction

  function automatic void model_edge();
    op_t cur;
    op_t f;
    int p;
    int s;
    int add;
    int hi;
    int lo;
    logic [W-1:0] yl;
    if (acc_clr) for (int i = 0; i < L; i++) macc[i] = 0;
    if (m_v && !out_ready) return;
    cur = '{v: in_valid, mode: mode, a: a, b: b, c: c};
    pq.push_back(cur);
    f = pq.pop_front();
    m_v = f.v;
    if (!f.v) return;
    hi = (1 << (W-1)) - 1;
    lo = -(1 << (W-1));
    for (int i = 0; i < L; i++) begin
      p = int'($signed(f.a[i*W +: W])) * int'($signed(f.b[i*W +: W]));
      add = f.mode ? macc[i] : int'($signed(f.c[i*W +: W]));
      s = p + add;
      m_ovf[i] = (s > hi) || (s < lo);
`ifdef ADD_MUL_PIPE_SAT_EN
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`endif
      yl = s[W-1:0];
      m_y[i*W +: W] = yl;
      if (f.mode) macc[i] = int'($signed(yl));
    end
  endfunction

  task automatic compare();
    check("out_valid", {63'd0, out_valid}, {63'd0, m_v});
    check("in_ready", {63'd0, in_ready}, {63'd0, !(m_v && !out_ready)});
    if (m_v) begin
      check("y", {32'd0, y}, {32'd0, m_y});
      check("ovf", {60'd0, ovf}, {60'd0, m_ovf});
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) begin
      if (cand_v && out_ready) begin
        obs.push_back(cand_y);
        $display("txn %0d: y=%h ovf=%b", ntx, cand_y, cand_ovf);
        ntx++;
      end
      model_edge();
    end
    #1;
    compare();
    cand_v = out_valid;
    cand_y = y;
    cand_ovf = ovf;
  endtask

  vec_t tbl[3];
  int   idx;
  int   cyc;
  logic acc_ok;
  logic [L*W-1:0] exp_y;

  initial begin
    tbl[0] = '{name: "v4x2p3", a: 32'h00000004, b: 32'h00000002, c: 32'h00000003,
               ey: 32'h0000000B, eovf: 4'b0000};
`ifdef ADD_MUL_PIPE_SAT_EN
    tbl[1] = '{name: "v100x2", a: 32'h00000064, b: 32'h00000002, c: 32'h00000000,
               ey: 32'h0000007F, eovf: 4'b0001};
    tbl[2] = '{name: "v4lane", a: 32'h8007FE01, b: 32'h01070301, c: 32'hFFCF0001,
               ey: 32'h8000FA02, eovf: 4'b1000};
`else
    tbl[1] = '{name: "v100x2", a: 32'h00000064, b: 32'h00000002, c: 32'h00000000,
               ey: 32'h000000C8, eovf: 4'b0001};
    tbl[2] = '{name: "v4lane", a: 32'h8007FE01, b: 32'h01070301, c: 32'hFFCF0001,
               ey: 32'h7F00FA02, eovf: 4'b1000};
`endif

    reset = 1'b0; in_valid = 1'b0; mode = 1'b0; acc_clr = 1'b0;
    a = '0; b = '0; c = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y", {32'd0, y}, 64'd0);
    check("rst_ovf", {60'd0, ovf}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    #2 reset = 1'b1;

    // Directed vectors: result must be present exactly after S edges from acceptance.
    for (int t = 0; t < 3; t++) begin
      a = tbl[t].a; b = tbl[t].b; c = tbl[t].c; mode = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0; a = '0; b = '0; c = '0;
      repeat (S-1) step();
      check({tbl[t].name, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({tbl[t].name, "_y"}, {32'd0, y}, {32'd0, tbl[t].ey});
      check({tbl[t].name, "_ovf"}, {60'd0, ovf}, {60'd0, tbl[t].eovf});
      step();
    end

    // Accumulate: clear, three 3*5 adds, then a fourth that meets a clear in the final stage.
    obs.delete();
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    mode = 1'b1; a = {4{8'd3}}; b = {4{8'd5}}; c = 32'h5A5AA5A5; in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (n == 3 && S == 1) acc_clr = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (S > 1) begin
      repeat (S-2) step();
      acc_clr = 1'b1;
      step();
    end
    acc_clr = 1'b0;
    repeat (S+1) step();
    check("acc_count", obs.size(), 4);
    if (obs.size() == 4) begin
      check("acc_y0", {32'd0, obs[0]}, {32'd0, {4{8'd15}}});
      check("acc_y1", {32'd0, obs[1]}, {32'd0, {4{8'd30}}});
      check("acc_y2", {32'd0, obs[2]}, {32'd0, {4{8'd45}}});
      check("acc_y3", {32'd0, obs[3]}, {32'd0, {4{8'd15}}});
    end

    // Stream 8 inputs with a 5-cycle downstream stall in the middle.
    obs.delete();
    mode = 1'b0; idx = 0; cyc = 0;
    while (idx < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      for (int j = 0; j < L; j++) begin
        a[j*W +: W] = W'(idx + 1);
        b[j*W +: W] = W'(j + 1);
        c[j*W +: W] = W'(idx);
      end
      in_valid = 1'b1;
      #1;
      acc_ok = in_ready;
      if (cyc >= 5 && cyc < 9) check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      if (acc_ok) idx++;
      cyc++;
    end
    check("stall_all_sent", idx, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S+2) step();
    check("stall_count", obs.size(), 8);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < L; j++) exp_y[j*W +: W] = W'((i + 1) * (j + 1) + i);
      if (i < obs.size()) check("stall_order", {32'd0, obs[i]}, {32'd0, exp_y});
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      acc_clr   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; c = $urandom;
      step();
    end
    acc_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (S+1) step();

    // Reset with two transactions in flight: nothing from them may ever appear.
    mode = 1'b0; in_valid = 1'b1;
    a = 32'h01010101; b = 32'h02020202; c = '0; step();
    a = 32'h03030303; step();
    in_valid = 1'b0;
    check("inflight_out_valid", {63'd0, out_valid}, 64'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_y", {32'd0, y}, 64'd0);
    repeat (2) step();
    #2 reset = 1'b1;
    obs.delete();
    a = 32'h02020202; b = 32'h02020202; c = 32'h01010101; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (S+3) step();
    check("rst_obs_count", obs.size(), 1);
    if (obs.size() >= 1) check("rst_obs_y", {32'd0, obs[0]}, 64'h05050505);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
